// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline types for the RV32I core; the hazard controller's state encoding lives here.
package rv32i_types;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2,
    LUSE  = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use detector: flags an ID instruction that reads the register a load in EX is producing.
module load_use_detect
  import rv32i_types::*;
(
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              lu_hit
);

  logic rs1_match;
  logic rs2_match;

  always_comb begin
    rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is never really written, so a load into it cannot create a hazard
    lu_hit    = ex_is_load && (ex_rd != '0) && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, redirect flush and one-cycle load-use bubble,
// with wrapping event counters.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             en_pc,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [1:0]       state_o
);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic             lu_hit;
  logic             mem_busy;
  logic             stall_inc, flush_inc, lu_inc;

  load_use_detect u_lu_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .lu_hit     (lu_hit)
  );

  assign mem_busy = (imem_req && !imem_resp) || (dmem_req && !dmem_resp);

  always_comb begin
    state_d      = state_q;
    en_pc        = 1'b0;
    en_if_id     = 1'b0;
    en_id_ex     = 1'b0;
    en_ex_mem    = 1'b0;
    en_mem_wb    = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    lu_inc       = 1'b0;

    if (state_q == INIT) begin
      state_d = RUN;
    end else if (mem_busy) begin
      state_d   = MWAIT;
      stall_inc = 1'b1;
    end else begin
      // Release from MWAIT behaves exactly like RUN; only LUSE suppresses a second bubble.
      en_pc     = 1'b1;
      en_if_id  = 1'b1;
      en_id_ex  = 1'b1;
      en_ex_mem = 1'b1;
      en_mem_wb = 1'b1;
      state_d   = RUN;
      if (ex_br_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
        flush_inc    = 1'b1;
      end else if (lu_hit && (state_q != LUSE)) begin
        en_pc        = 1'b0;
        en_if_id     = 1'b0;
        bubble_id_ex = 1'b1;
        state_d      = LUSE;
        lu_inc       = 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q + CNT_W'(stall_inc);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_inc);
    lu_cnt_d    = lu_cnt_q + CNT_W'(lu_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign lu_cnt    = lu_cnt_q;
  assign state_o   = state_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of each event counter.
REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1/rs2.
REQ-006 SHALL have ports ex_rd  input  5 and ex_is_load  input  1  destination of, and load flag for, the instruction in EX.
REQ-007 SHALL have port ex_br_taken  input  1  EX resolves a taken branch or jump (PC redirect).
REQ-008 SHALL have ports imem_req, imem_resp, dmem_req, dmem_resp  input  1 each  fetch and MEM-stage memory request/response.
REQ-009 SHALL have ports en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  output  1 each  pipeline register load enables.
REQ-010 SHALL have ports flush_if_id, bubble_id_ex  output  1 each  zero (NOP) the IF/ID or ID/EX register on the next load.
REQ-011 SHALL have ports stall_cnt, flush_cnt, lu_cnt  output  CNT_W each  event counters.
REQ-012 SHALL have port state_o  output  2  current FSM state, for debug.

Function
REQ-013 SHALL implement FSM states INIT, RUN, MWAIT, LUSE.
REQ-014 SHALL define mem_busy = (imem_req & ~imem_resp) | (dmem_req & ~dmem_resp).
REQ-015 SHALL define lu_hit = ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-016 SHALL, in INIT, drive all enables, flush_if_id and bubble_id_ex to 0, then enter RUN on the next edge.
REQ-017 SHALL, whenever mem_busy=1 in RUN, MWAIT or LUSE, drive all five enables to 0, flush_if_id and bubble_id_ex to 0, and enter/stay in MWAIT.
REQ-018 SHALL leave MWAIT for RUN on the first edge with mem_busy=0; that release cycle is evaluated by the RUN rules (REQ-019..021).
REQ-019 SHALL, in RUN or MWAIT with mem_busy=0 and ex_br_taken=1, assert all enables, flush_if_id=1 and bubble_id_ex=1; redirect outranks load-use.
REQ-020 SHALL, in RUN with mem_busy=0, ex_br_taken=0 and lu_hit=1, drive en_pc=en_if_id=0, bubble_id_ex=1, other enables 1, and enter LUSE.
REQ-021 SHALL otherwise assert all enables with flush_if_id=bubble_id_ex=0.
REQ-022 SHALL, in LUSE with mem_busy=0, act as RUN except that lu_hit is ignored, then return to RUN. Bubble length is exactly 1 cycle.
REQ-023 SHALL make all outputs except counters and state_o combinational from state and inputs. Latency from input to enable/flush is 0 cycles.
REQ-024 SHALL increment stall_cnt once per cycle in which REQ-017 holds.
REQ-025 SHALL increment flush_cnt once per cycle in which REQ-019 holds.
REQ-026 SHALL increment lu_cnt once per entry into LUSE.
REQ-027 SHALL let all counters wrap modulo 2^CNT_W without saturation or flag.
REQ-028 SHALL treat a redirect arriving while frozen as held: EX is frozen, so ex_br_taken persists and the flush occurs on the release cycle.

Reset
REQ-029 SHALL, while rst_n=0, set state INIT and clear all counters immediately; en_*, flush_if_id and bubble_id_ex read 0.
REQ-030 SHALL, if rst_n asserts mid-MWAIT or mid-LUSE, discard the pending state; no bubble or flush is replayed after reset.

Structure
REQ-031 SHALL place the state enum hazard_state_t (INIT, RUN, MWAIT, LUSE) in the shared rv32i_types package.
REQ-032 SHALL implement lu_hit in one combinational sub-module load_use_detect; the FSM and counters live in hazard_ctrl.

Verification
REQ-033 Reset: hold rst_n=0 for 3 cycles, then release -> all enables 0 in INIT and counters 0; en_* = 1 in RUN on the following cycle.
REQ-034 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with en_pc=en_if_id=0 and bubble_id_ex=1; lu_cnt 0->1; RUN two edges later.
REQ-035 Memory wait: dmem_req=1 with dmem_resp delayed 4 cycles -> 4 cycles of all enables 0; stall_cnt=4; resume in the cycle dmem_resp=1.
REQ-036 Redirect during freeze: ex_br_taken=1 while imem_resp is pending for 3 cycles -> no flush while frozen; flush_if_id=bubble_id_ex=1 on the release cycle; flush_cnt=1.
REQ-037 Priority: ex_br_taken=1 together with a lu_hit condition -> flush only; lu_cnt unchanged; no LUSE entry.
REQ-038 Wrap and x0: CNT_W=4 with 17 stall cycles -> stall_cnt=1; load with ex_rd=0 matching id_rs1=0 -> no bubble.
